// File: rtl/decim_sched_pkg.sv
// Shared types and constants for the decimation-chain enable scheduler.
package decim_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } sched_state_t;

   localparam int STAGE_IDX_W = 3;

   // Stage 0 in the LSBs: divide-by-4, divide-by-8, divide-by-10.
   localparam logic [23:0] DEF_INIT_RATIO = {8'd9, 8'd7, 8'd3};

endpackage

// File: rtl/decim_enable_scheduler_if.sv
// Ratio configuration channel. A transfer happens on any cycle with
// cfg_valid & cfg_ready; the master holds stage/ratio stable until then.
interface decim_enable_scheduler_if #(
   parameter int RATIO_W = 8
);
   logic                                   cfg_valid;
   logic                                   cfg_ready;
   logic [decim_sched_pkg::STAGE_IDX_W-1:0] cfg_stage;
   logic [RATIO_W-1:0]                     cfg_ratio;
   logic                                   cfg_err;

   modport master (
      output cfg_valid, cfg_stage, cfg_ratio,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_stage, cfg_ratio,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/decim_sched_stage.sv
// One divider stage: counts strobes and passes every (ratio+1)-th one through.
module decim_sched_stage #(
   parameter int RATIO_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               strobe,
   input  logic               clear,
   input  logic [RATIO_W-1:0] ratio,
   output logic               en
);

   logic [RATIO_W-1:0] cnt;
   logic               at_term;

   assign at_term = (cnt == ratio);
   assign en      = strobe & at_term;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (strobe) begin
         cnt <= at_term ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/decim_enable_scheduler.sv
// Cascaded clock-enable scheduler; new ratios land only on frame boundaries,
// sync pulses, or when the chain is halted.
module decim_enable_scheduler
   import decim_sched_pkg::*;
#(
   parameter int                         STAGES     = 3,
   parameter int                         RATIO_W    = 8,
   parameter logic [STAGES*RATIO_W-1:0]  INIT_RATIO = DEF_INIT_RATIO
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          run_i,
   input  logic                          sync_i,
   input  logic                          en_i,
   output logic [STAGES-1:0]             en_o,
   decim_enable_scheduler_if.slave       cfg,
   output logic                          pending_o,
   output sched_state_t                  state_o
);

   sched_state_t            state;
   logic [RATIO_W-1:0]      ratio [STAGES];
   logic [STAGE_IDX_W-1:0]  sh_stage;
   logic [RATIO_W-1:0]      sh_ratio;
   logic                    cfg_err_q;

   logic                    run_state;
   logic                    xfer;
   logic                    bad_stage;
   logic                    boundary;
   logic                    clear;
   logic                    s0;

   logic                    wr_en;
   logic [STAGE_IDX_W-1:0]  wr_stage;
   logic [RATIO_W-1:0]      wr_ratio;

   assign run_state     = (state != IDLE);
   assign cfg.cfg_ready = (state != PEND);
   assign cfg.cfg_err   = cfg_err_q;
   assign state_o       = state;
   assign xfer          = cfg.cfg_valid & cfg.cfg_ready;
   assign bad_stage     = {1'b0, cfg.cfg_stage} >= (STAGE_IDX_W + 1)'(STAGES);
   assign boundary      = en_o[STAGES-1];
   assign clear         = ~run_state | ~run_i | sync_i | boundary;
   // The sync cycle is silent on every stage, not just stage 0.
   assign s0            = en_i & run_state & ~sync_i;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic stb;
      logic en;

      if (k == 0) begin : g_first
         assign stb = s0;
      end else begin : g_next
         assign stb = g_stage[k-1].en;
      end

      decim_sched_stage #(.RATIO_W(RATIO_W)) u_stage (
         .clk    (clk),
         .reset  (reset),
         .strobe (stb),
         .clear  (clear),
         .ratio  (ratio[k]),
         .en     (en)
      );

      assign en_o[k] = en;
   end

   // Single ratio write port: either the held shadow or a direct write while halted.
   always_comb begin
      wr_en    = 1'b0;
      wr_stage = cfg.cfg_stage;
      wr_ratio = cfg.cfg_ratio;
      if (state == PEND) begin
         wr_en    = ~run_i | sync_i | boundary;
         wr_stage = sh_stage;
         wr_ratio = sh_ratio;
      end else begin
         wr_en = xfer & ~bad_stage & ((state == IDLE) | ~run_i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         sh_stage  <= '0;
         sh_ratio  <= '0;
         pending_o <= 1'b0;
         cfg_err_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            ratio[k] <= INIT_RATIO[k*RATIO_W +: RATIO_W];
         end
      end else begin
         cfg_err_q <= xfer & bad_stage;

         for (int k = 0; k < STAGES; k++) begin
            if (wr_en && (wr_stage == STAGE_IDX_W'(k))) begin
               ratio[k] <= wr_ratio;
            end
         end

         case (state)
            IDLE: begin
               if (run_i) state <= RUN;
            end
            RUN: begin
               if (!run_i) begin
                  state <= IDLE;
               end else if (xfer && !bad_stage) begin
                  sh_stage  <= cfg.cfg_stage;
                  sh_ratio  <= cfg.cfg_ratio;
                  pending_o <= 1'b1;
                  state     <= PEND;
               end
            end
            PEND: begin
               if (!run_i || sync_i || boundary) begin
                  pending_o <= 1'b0;
                  state     <= run_i ? RUN : IDLE;
               end
            end
            default: begin
               pending_o <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decim_enable_scheduler.sv
// Bench for decim_enable_scheduler: a frame-count reference model feeds an
// expected-enable queue that is checked every cycle on the falling edge.
module tb_decim_enable_scheduler;
   import decim_sched_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         run_i;
   logic         sync_i;
   logic         en_i;
   logic [2:0]   en_o;
   logic         pending_o;
   sched_state_t state_o;

   decim_enable_scheduler_if #(.RATIO_W(8)) cfg ();

   decim_enable_scheduler #(
      .STAGES     (3),
      .RATIO_W    (8),
      .INIT_RATIO ({8'd9, 8'd7, 8'd3})
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .run_i     (run_i),
      .sync_i    (sync_i),
      .en_i      (en_i),
      .en_o      (en_o),
      .cfg       (cfg),
      .pending_o (pending_o),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [2:0] exp_q[$];
   bit         check_on     = 1'b0;

   // Reference model: 0 = halted, 1 = running, 2 = config waiting.
   int m_state;
   int m_ratio [3];
   int m_sh_stage;
   int m_sh_ratio;
   int m_n;
   bit m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state    = 0;
      m_ratio[0] = 3;
      m_ratio[1] = 7;
      m_ratio[2] = 9;
      m_sh_stage = 0;
      m_sh_ratio = 0;
      m_n        = 0;
      m_err      = 1'b0;
   endtask

   task automatic model_commit(input bit run);
      m_ratio[m_sh_stage] = m_sh_ratio;
      m_state             = run ? 1 : 0;
   endtask

   // One clock cycle: drive, predict, check at negedge, advance model at posedge.
   task automatic cyc(input bit rst, input bit en, input bit run, input bit sync,
                      input bit valid, input int stage, input int ratio);
      logic [2:0] e;
      logic [2:0] e_pop;
      int         p;
      bit         xfer;
      bit         bad;

      reset          = rst;
      en_i           = en;
      run_i          = run;
      sync_i         = sync;
      cfg.cfg_valid  = valid;
      cfg.cfg_stage  = 3'(stage);
      cfg.cfg_ratio  = 8'(ratio);

      e = 3'b000;
      if (m_state != 0 && !sync && en) begin
         p = 1;
         for (int k = 0; k < 3; k++) begin
            p = p * (m_ratio[k] + 1);
            if (((m_n + 1) % p) == 0) e[k] = 1'b1;
         end
      end
      exp_q.push_back(e);

      @(negedge clk);
      e_pop = exp_q.pop_front();
      if (check_on) begin
         check("en_o", 32'(en_o), 32'(e_pop));
         check("cfg_ready", 32'(cfg.cfg_ready), 32'(m_state != 2));
         check("pending_o", 32'(pending_o), 32'(m_state == 2));
         check("cfg_err", 32'(cfg.cfg_err), 32'(m_err));
         check("state", 32'(state_o), 32'(m_state));
      end

      @(posedge clk);
      xfer = valid && (m_state != 2);
      bad  = (stage >= 3);
      if (rst) begin
         model_reset();
      end else begin
         m_err = xfer && bad;
         if (m_state == 0) begin
            m_n = 0;
            if (xfer && !bad) m_ratio[stage] = ratio;
            if (run) m_state = 1;
         end else if (!run) begin
            if (m_state == 2) model_commit(1'b0);
            else if (xfer && !bad) m_ratio[stage] = ratio;
            m_state = 0;
            m_n     = 0;
         end else if (sync) begin
            m_n = 0;
            if (m_state == 2) begin
               model_commit(1'b1);
            end else if (xfer && !bad) begin
               m_sh_stage = stage;
               m_sh_ratio = ratio;
               m_state    = 2;
            end
         end else begin
            if (en) m_n = e[2] ? 0 : m_n + 1;
            if (m_state == 2) begin
               if (e[2]) model_commit(1'b1);
            end else if (xfer && !bad) begin
               m_sh_stage = stage;
               m_sh_ratio = ratio;
               m_state    = 2;
            end
         end
      end
      #1;
   endtask

   initial begin
      model_reset();
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      check_on = 1'b1;

      // Post-reset idle, en_i ignored while halted.
      repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);

      // Default ratios, continuous base strobe: two full 320-sample frames.
      repeat (700) cyc(0, 1, 1, 0, 0, 0, 0);

      // Mid-frame write of stage 1 -> divide-by-2, held until the boundary.
      cyc(0, 1, 1, 0, 1, 1, 1);
      repeat (400) cyc(0, 1, 1, 0, 0, 0, 0);
      repeat (500) cyc(0, 1'($urandom_range(0, 1)), 1, 0, 0, 0, 0);

      // Out-of-range stage while running: error pulse, no pending.
      cyc(0, 1, 1, 0, 1, 5, 2);
      repeat (30) cyc(0, 1'($urandom_range(0, 1)), 1, 0, 0, 0, 0);

      // Halt, out-of-range and direct writes while idle, then rerun with divide-by-1.
      repeat (2) cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 6, 1);
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      repeat (100) cyc(0, 1, 1, 0, 0, 0, 0);
      repeat (100) cyc(0, 1'($urandom_range(0, 1)), 1, 0, 0, 0, 0);

      // Pending config forced in by a sync pulse.
      cyc(0, 0, 1, 0, 1, 2, 2);
      repeat (2) cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 1, 1, 1, 0, 0, 0);
      repeat (200) cyc(0, 1'($urandom_range(0, 1)), 1, 0, 0, 0, 0);

      // Reset while a config is pending and counters are mid-count.
      cyc(0, 0, 1, 0, 1, 0, 5);
      repeat (2) cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0, 0);
      repeat (700) cyc(0, 1, 1, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
